// File: rtl/cbuf_pkg.sv
// Shared defaults and helpers for the circular buffer datapath.
package cbuf_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 4;

  // Ceiling log2, usable in constant expressions for pointer sizing.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/circular_buffer_datapath_if.sv
// Strobe/status bundle between the buffer controller and the datapath.
interface circular_buffer_datapath_if
  import cbuf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
);

  localparam int ADDR_W = clog2(DEPTH);

  logic                  init;
  logic                  wen;
  logic                  inc_w;
  logic                  inc_r;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  ready;
  logic                  valid;
  logic [ADDR_W:0]       count;

  // Controller side: issues strobes, watches status.
  modport master (
    output init, wen, inc_w, inc_r, din,
    input  dout, ready, valid, count
  );

  // Datapath side: consumes strobes, reports status.
  modport slave (
    input  init, wen, inc_w, inc_r, din,
    output dout, ready, valid, count
  );

endinterface

// File: rtl/cbuf_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
module cbuf_mem
  import cbuf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_W     = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    // Each word captures wdata only when it is the addressed write target.
    always_ff @(posedge clk) begin
      if (we && (waddr == ADDR_W'(gi))) begin
        mem[gi] <= wdata;
      end
    end
  end

  // Head word is visible without a clock so the buffer falls through.
  assign rdata = mem[raddr];

endmodule

// File: rtl/circular_buffer_datapath.sv
// Pointer, accept and status logic of the circular buffer; storage in cbuf_mem.
module circular_buffer_datapath
  import cbuf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  circular_buffer_datapath_if.slave   bus
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0] wptr_reg;
  logic [ADDR_W:0] rptr_reg;
  logic            full;
  logic            empty;
  logic            wr_ok;
  logic            rd_ok;

  assign empty = (wptr_reg == rptr_reg);
  assign full  = (wptr_reg[ADDR_W-1:0] == rptr_reg[ADDR_W-1:0]) &&
                 (wptr_reg[ADDR_W] != rptr_reg[ADDR_W]);

  assign wr_ok = bus.wen & bus.inc_w & ~full;
  assign rd_ok = bus.inc_r & ~empty;

  // Pointer update: init clears both and overrides any same-cycle access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else if (bus.init) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (wr_ok) begin
        wptr_reg <= wptr_reg + PTR_ONE;
      end
      if (rd_ok) begin
        rptr_reg <= rptr_reg + PTR_ONE;
      end
    end
  end

  cbuf_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok & ~bus.init),
    .waddr (wptr_reg[ADDR_W-1:0]),
    .wdata (bus.din),
    .raddr (rptr_reg[ADDR_W-1:0]),
    .rdata (bus.dout)
  );

  // Status depends on registered pointers only.
  assign bus.ready = ~full;
  assign bus.valid = ~empty;
  assign bus.count = wptr_reg - rptr_reg;

endmodule

// File: tb/tb_circular_buffer_datapath.sv
// Randomised and directed checks of circular_buffer_datapath against a queue model.
module tb_circular_buffer_datapath;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  circular_buffer_datapath_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  circular_buffer_datapath #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  logic [DW-1:0] model_q[$];

  // One clock of stimulus; the model follows the FIFO rules on the same edge.
  task automatic drive(input logic w, input logic iw, input logic ir,
                       input logic in, input logic [DW-1:0] d);
    bit push;
    bit pop;
    bus.wen   = w;
    bus.inc_w = iw;
    bus.inc_r = ir;
    bus.init  = in;
    bus.din   = d;
    @(posedge clk);
    if (in) begin
      model_q.delete();
    end else begin
      push = w && iw && (model_q.size() < DEPTH);
      pop  = ir && (model_q.size() > 0);
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back(d);
    end
    #1;
    bus.wen = 0; bus.inc_w = 0; bus.inc_r = 0; bus.init = 0;
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.count !== 0 || bus.ready !== 1'b1 || bus.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_initial: count=%0d ready=%b valid=%b required 0/1/0",
               bus.count, bus.ready, bus.valid);
    end
    drive(1, 1, 0, 0, 8'h01);
    drive(1, 1, 0, 0, 8'h02);
    vectors++;
    if (bus.count !== 2) begin
      miscompares++;
      $display("FAIL reset_prefill: count=%0d required 2", bus.count);
    end
    #2 rst = 1'b0;
    #1;
    model_q.delete();
    vectors++;
    if (bus.count !== 0 || bus.ready !== 1'b1 || bus.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: count=%0d ready=%b valid=%b required 0/1/0",
               bus.count, bus.ready, bus.valid);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    drive(1, 1, 0, 0, 8'h5A);
    vectors++;
    if (bus.count !== 1 || bus.valid !== 1'b1 || bus.dout !== 8'h5A) begin
      miscompares++;
      $display("FAIL reset_first_write: count=%0d valid=%b dout=%h required 1/1/5a",
               bus.count, bus.valid, bus.dout);
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, vals[i]);
      vectors++;
      if (bus.count !== (3)'(i + 1)) begin
        miscompares++;
        $display("FAIL fill_count: step %0d count=%0d required %0d", i, bus.count, i + 1);
      end
    end
    drive(1, 1, 0, 0, 8'h55);
    vectors++;
    if (bus.count !== 4 || bus.ready !== 1'b0 || bus.dout !== 8'h11) begin
      miscompares++;
      $display("FAIL fill_overflow: count=%0d ready=%b dout=%h required 4/0/11",
               bus.count, bus.ready, bus.dout);
    end
  endtask

  task automatic test_drain();
    logic [DW-1:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.valid !== 1'b1 || bus.dout !== vals[i]) begin
        miscompares++;
        $display("FAIL drain_head: pop %0d valid=%b dout=%h required 1/%h",
                 i, bus.valid, bus.dout, vals[i]);
      end
      drive(0, 0, 1, 0, 8'h00);
    end
    vectors++;
    if (bus.valid !== 1'b0 || bus.count !== 0) begin
      miscompares++;
      $display("FAIL drain_empty: valid=%b count=%0d required 0/0", bus.valid, bus.count);
    end
    drive(0, 0, 1, 0, 8'h00);
    vectors++;
    if (bus.count !== 0 || bus.valid !== 1'b0 || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_underflow: count=%0d valid=%b ready=%b required 0/0/1",
               bus.count, bus.valid, bus.ready);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_head;
    drive(1, 1, 0, 0, 8'h9E);
    drive(1, 1, 0, 0, 8'h9F);
    for (int i = 0; i < 10; i++) begin
      exp_head = model_q[0];
      vectors++;
      if (bus.dout !== exp_head) begin
        miscompares++;
        $display("FAIL wrap_pop: cycle %0d dout=%h required %h", i, bus.dout, exp_head);
      end
      drive(1, 1, 1, 0, 8'hA0 + DW'(i));
      vectors++;
      if (bus.count !== 2) begin
        miscompares++;
        $display("FAIL wrap_count: cycle %0d count=%0d required 2", i, bus.count);
      end
    end
  endtask

  task automatic test_simultaneous();
    drive(0, 0, 0, 1, 8'h00);
    drive(1, 1, 1, 0, 8'h7E);
    vectors++;
    if (bus.count !== 1 || bus.dout !== 8'h7E || bus.valid !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_empty: count=%0d dout=%h valid=%b required 1/7e/1",
               bus.count, bus.dout, bus.valid);
    end
    drive(1, 1, 0, 0, 8'h81);
    drive(1, 1, 0, 0, 8'h82);
    drive(1, 1, 0, 0, 8'h83);
    drive(1, 1, 1, 0, 8'h99);
    vectors++;
    if (bus.count !== 3 || bus.ready !== 1'b1 || bus.dout !== 8'h81) begin
      miscompares++;
      $display("FAIL simul_full: count=%0d ready=%b dout=%h required 3/1/81",
               bus.count, bus.ready, bus.dout);
    end
  endtask

  task automatic test_init();
    drive(1, 1, 0, 1, 8'hC3);
    vectors++;
    if (bus.count !== 0 || bus.valid !== 1'b0 || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL init_clear: count=%0d valid=%b ready=%b required 0/0/1",
               bus.count, bus.valid, bus.ready);
    end
    drive(1, 1, 0, 0, 8'h3C);
    vectors++;
    if (bus.count !== 1 || bus.dout !== 8'h3C) begin
      miscompares++;
      $display("FAIL init_after: count=%0d dout=%h required 1/3c", bus.count, bus.dout);
    end
  endtask

  task automatic test_random();
    logic w, iw, ir, in;
    for (int i = 0; i < 300; i++) begin
      w  = ($urandom_range(0, 9) < 6);
      iw = ($urandom_range(0, 9) < 9) ? w : ~w;
      ir = ($urandom_range(0, 9) < 5);
      in = ($urandom_range(0, 49) == 0);
      drive(w, iw, ir, in, DW'($urandom));
      vectors++;
      if (bus.count !== (3)'(model_q.size()) ||
          bus.valid !== (model_q.size() != 0) ||
          bus.ready !== (model_q.size() != DEPTH) ||
          (model_q.size() != 0 && bus.dout !== model_q[0])) begin
        miscompares++;
        $display("FAIL random_step: iter %0d count=%0d valid=%b ready=%b dout=%h required count %0d head %h",
                 i, bus.count, bus.valid, bus.ready, bus.dout, model_q.size(),
                 (model_q.size() != 0) ? model_q[0] : 8'h00);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b0;
    bus.init  = 0;
    bus.wen   = 0;
    bus.inc_w = 0;
    bus.inc_r = 0;
    bus.din   = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_init();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
